// File: rtl/seg_scan_driver.sv
// seg_scan_driver: N-digit multiplexed hex 7-segment scanner, frame-synchronous double buffer.
// Optional leading-zero blanking when SEG_LZ_BLANK_EN is defined.
module seg_scan_driver #(
  parameter int N_DIGITS = 4,
  parameter int DIV      = 50000
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [4*N_DIGITS-1:0] DataIn,
  input  logic [N_DIGITS-1:0]   DpIn,
  input  logic                  Load,
  input  logic [N_DIGITS-1:0]   BlankMask,
  output logic [0:6]            SegOut,
  output logic                  DpOut,
  output logic [N_DIGITS-1:0]   AnOut,
  output logic                  LoadAck
);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [PW-1:0] PreMax = PW'(DIV - 1);
  localparam logic [IW-1:0] IdxMax = IW'(N_DIGITS - 1);

  logic [PW-1:0]         preCnt;
  logic [IW-1:0]         idx;
  logic [4*N_DIGITS-1:0] holdData;
  logic [4*N_DIGITS-1:0] dispData;
  logic [N_DIGITS-1:0]   holdDp;
  logic [N_DIGITS-1:0]   dispDp;
  logic                  pending;
  logic                  tick;
  logic                  frameEnd;
  logic [3:0]            nib;
  logic                  dpBit;
  logic                  maskBit;
  logic                  lzBlank;
  logic [6:0]            segOn;
  logic [N_DIGITS-1:0]   anNext;

  assign tick     = (preCnt == PreMax);
  assign frameEnd = tick && (idx == IdxMax);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      preCnt <= '0;
      idx    <= '0;
    end else begin
      preCnt <= tick ? '0 : preCnt + PW'(1);
      if (tick)
        idx <= (idx == IdxMax) ? '0 : idx + IW'(1);
    end
  end

  // A Load coinciding with a transfer re-arms pending for the next frame.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      holdData <= '0;
      holdDp   <= '0;
      dispData <= '0;
      dispDp   <= '0;
      pending  <= 1'b0;
      LoadAck  <= 1'b0;
    end else begin
      LoadAck <= frameEnd && pending;
      if (frameEnd && pending) begin
        dispData <= holdData;
        dispDp   <= holdDp;
      end
      if (Load) begin
        holdData <= DataIn;
        holdDp   <= DpIn;
        pending  <= 1'b1;
      end else if (frameEnd) begin
        pending  <= 1'b0;
      end
    end
  end

  always_comb begin
    nib     = '0;
    dpBit   = 1'b0;
    maskBit = 1'b0;
    lzBlank = 1'b0;
    anNext  = '1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib       = dispData[4*i +: 4];
        dpBit     = dispDp[i];
        maskBit   = BlankMask[i];
        anNext[i] = 1'b0;
`ifdef SEG_LZ_BLANK_EN
        lzBlank   = (i != 0) && ((dispData >> (4*i)) == '0);
`else
        lzBlank   = 1'b0;
`endif
      end
    end
  end

  always_comb begin
    segOn = 7'b0000000;
    unique case (nib)
      4'h0: segOn = 7'b1111110;
      4'h1: segOn = 7'b0110000;
      4'h2: segOn = 7'b1101101;
      4'h3: segOn = 7'b1111001;
      4'h4: segOn = 7'b0110011;
      4'h5: segOn = 7'b1011011;
      4'h6: segOn = 7'b1011111;
      4'h7: segOn = 7'b1110000;
      4'h8: segOn = 7'b1111111;
      4'h9: segOn = 7'b1111011;
      4'hA: segOn = 7'b1110111;
      4'hB: segOn = 7'b0011111;
      4'hC: segOn = 7'b1001110;
      4'hD: segOn = 7'b0111101;
      4'hE: segOn = 7'b1001111;
      4'hF: segOn = 7'b1000111;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      SegOut <= '1;
      DpOut  <= 1'b1;
      AnOut  <= '1;
    end else begin
      AnOut  <= anNext;
      SegOut <= (maskBit || lzBlank) ? 7'b1111111 : ~segOn;
      DpOut  <= maskBit | ~dpBit;
    end
  end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed + random stimulus vs. a cycle-count reference model.
// Model derives slot/frame timing arithmetically from edges since reset.
module tb_seg_scan_driver;
  localparam int N = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         load = 1'b0;
  logic [15:0]  dataIn = '0;
  logic [3:0]   dpIn = '0;
  logic [3:0]   blankMask = '0;
  logic [0:6]   segOut;
  logic         dpOut;
  logic [3:0]   anOut;
  logic         loadAck;

  int vectors = 0;
  int miscompares = 0;
  int k = 0;
  int acks = 0;

  logic [15:0] mHold = '0;
  logic [15:0] mDisp = '0;
  logic [3:0]  mHDp = '0;
  logic [3:0]  mDDp = '0;
  bit          mPend = 1'b0;
  logic [3:0]  curMask = '0;

  logic [6:0] hexTbl [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  seg_scan_driver #(.N_DIGITS(N), .DIV(D)) dut (
    .Clk(clk),
    .Reset(reset),
    .DataIn(dataIn),
    .DpIn(dpIn),
    .Load(load),
    .BlankMask(blankMask),
    .SegOut(segOut),
    .DpOut(dpOut),
    .AnOut(anOut),
    .LoadAck(loadAck)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h k=%0d", tag, obs, exp, k);
    end
  endtask

  task automatic step(bit rst, bit ld, logic [15:0] d, logic [3:0] dp);
    logic [0:6] eSeg;
    logic [3:0] eAn;
    logic [3:0] nib;
    bit         eDp;
    bit         eAck;
    bit         lz;
    int         idx;
    @(negedge clk);
    reset = rst;
    load = ld;
    dataIn = d;
    dpIn = dp;
    blankMask = curMask;
    @(posedge clk);
    if (rst) begin
      k = 0;
      mHold = '0; mDisp = '0; mHDp = '0; mDDp = '0; mPend = 1'b0;
      eSeg = 7'b1111111; eDp = 1'b1; eAn = 4'hF; eAck = 1'b0;
    end else begin
      k++;
      idx = ((k - 1) / D) % N;
      nib = mDisp[4*idx +: 4];
`ifdef SEG_LZ_BLANK_EN
      lz = (idx >= 1) && ((mDisp >> (4*idx)) == 16'h0);
`else
      lz = 1'b0;
`endif
      eSeg = (curMask[idx] || lz) ? 7'b1111111 : ~hexTbl[nib];
      eDp = curMask[idx] ? 1'b1 : ~mDDp[idx];
      eAn = ~(4'b0001 << idx);
      eAck = ((k % (N*D)) == 0) && mPend;
      if (eAck) begin
        mDisp = mHold; mDDp = mHDp; mPend = 1'b0;
      end
      if (ld) begin
        mHold = d; mHDp = dp; mPend = 1'b1;
      end
    end
    #1;
    if (loadAck === 1'b1) acks++;
    chk("SegOut", 32'(segOut), 32'(eSeg));
    chk("DpOut", 32'(dpOut), 32'(eDp));
    chk("AnOut", 32'(anOut), 32'(eAn));
    chk("LoadAck", 32'(loadAck), 32'(eAck));
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'($urandom), 4'($urandom));
  endtask

  task automatic toPhase(int ph);
    int guard;
    guard = 0;
    while ((((k + 1) % (N*D)) != ph) && guard < 64) begin
      idle(1);
      guard++;
    end
  endtask

  initial begin
    int a0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0, 4'h0);
    idle(1);
    chk("firstAn", 32'(anOut), 32'(4'b1110));
    chk("firstSeg", 32'(segOut), 32'(7'b0000001));
    idle(19);

    step(1'b0, 1'b1, 16'h3A7F, 4'b0010);
    idle(40);

    a0 = acks;
    toPhase(3);
    step(1'b0, 1'b1, 16'h1111, 4'h0);
    idle(3);
    step(1'b0, 1'b1, 16'h2222, 4'h0);
    idle(30);
    chk("oneAck", 32'(acks - a0), 32'd1);

    a0 = acks;
    toPhase(2);
    step(1'b0, 1'b1, 16'h1111, 4'h0);
    toPhase(0);
    step(1'b0, 1'b1, 16'hB00C, 4'h5);
    idle(34);
    chk("twoAcks", 32'(acks - a0), 32'd2);

    step(1'b0, 1'b1, 16'h9876, 4'b0100);
    curMask = 4'b0100;
    idle(40);
    curMask = 4'b0000;

    step(1'b0, 1'b1, 16'h0050, 4'h0);
    idle(36);
    step(1'b0, 1'b1, 16'h0000, 4'h0);
    idle(36);

    toPhase(0);
    step(1'b1, 1'b1, 16'hDEAD, 4'hF);
    idle(20);

    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 7) == 0)
        curMask = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      step($urandom_range(0, 299) == 0, $urandom_range(0, 9) == 0,
           16'($urandom), 4'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
